// File: rtl/zion_rr_clr_en_reg_arbiter.sv
// Round-robin arbiter sharing one clear/enable register among NUM_REQ requesters.
// A requester may lock ownership across transfers; an optional idle timeout forces release.
module zion_rr_clr_en_reg_arbiter #(
    parameter int unsigned       NUM_REQ  = 4,
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  INI_DATA = 32'h1,
    parameter int unsigned       LOCK_MAX = 16,
    localparam int unsigned      IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         iVld,
    input  logic [NUM_REQ-1:0]         iClr,
    input  logic [NUM_REQ-1:0]         iLock,
    input  logic [NUM_REQ*WIDTH-1:0]   iDat,
    output logic [NUM_REQ-1:0]         oRdy,
    output logic [WIDTH-1:0]           oDat,
    output logic [IDW-1:0]             oGntId,
    output logic                       oGntVld,
    output logic                       oLocked
);

    localparam int unsigned      CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_MAX == 0) ? 0 : LOCK_MAX - 1);
    localparam logic [IDW-1:0]   LAST_ID  = IDW'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dat_q, dat_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               gnt_vld_q, gnt_vld_d;

    logic [NUM_REQ-1:0] hi_req;
    logic               rr_any;
    logic [IDW-1:0]     rr_idx;
    logic [NUM_REQ-1:0] rdy;
    logic               commit;
    logic [IDW-1:0]     cmt_id;
    logic [WIDTH-1:0]   wdat;

    // Requests at or above the pointer win over wrapped-around ones.
    always_comb begin
        hi_req = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            hi_req[j] = iVld[j] && (j >= int'(ptr_q));
        end
    end

    always_comb begin
        rr_any = 1'b0;
        rr_idx = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (iVld[j]) begin
                rr_any = 1'b1;
                rr_idx = IDW'(j);
            end
        end
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (hi_req[j]) begin
                rr_any = 1'b1;
                rr_idx = IDW'(j);
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (!rst) begin
            if (state_q == ST_IDLE) begin
                if (rr_any) begin
                    rdy[rr_idx] = 1'b1;
                end
            end else begin
                rdy[owner_q] = iVld[owner_q];
            end
        end
    end

    assign commit = |(iVld & rdy);
    assign cmt_id = (state_q == ST_IDLE) ? rr_idx : owner_q;

    always_comb begin
        wdat = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (int'(cmt_id) == j) begin
                wdat = iDat[j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        dat_d     = dat_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = 1'b0;
        if (commit) begin
            dat_d     = iClr[cmt_id] ? INI_DATA : wdat;
            gnt_id_d  = cmt_id;
            gnt_vld_d = 1'b1;
            ptr_d     = (cmt_id == LAST_ID) ? '0 : cmt_id + 1'b1;
            cnt_d     = '0;
            if (iLock[cmt_id]) begin
                state_d = ST_LOCKED;
                owner_d = cmt_id;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_LOCKED && LOCK_MAX != 0) begin
            // Forced release hands priority to the requester after the stalled owner.
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                ptr_d   = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            dat_q     <= INI_DATA;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign oRdy    = rdy;
    assign oDat    = dat_q;
    assign oGntId  = gnt_id_q;
    assign oGntVld = gnt_vld_q;
    assign oLocked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_zion_rr_clr_en_reg_arbiter.sv
// Directed bench for zion_rr_clr_en_reg_arbiter: reset, rotation, clear, lock, timeout, reset mid-lock.
module tb_zion_rr_clr_en_reg_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       iVld;
    logic [NUM_REQ-1:0]       iClr;
    logic [NUM_REQ-1:0]       iLock;
    logic [NUM_REQ*WIDTH-1:0] iDat;
    logic [NUM_REQ-1:0]       oRdy;
    logic [WIDTH-1:0]         oDat;
    logic [1:0]               oGntId;
    logic                     oGntVld;
    logic                     oLocked;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    zion_rr_clr_en_reg_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (32),
        .INI_DATA(32'h1),
        .LOCK_MAX(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iVld   (iVld),
        .iClr   (iClr),
        .iLock  (iLock),
        .iDat   (iDat),
        .oRdy   (oRdy),
        .oDat   (oDat),
        .oGntId (oGntId),
        .oGntVld(oGntVld),
        .oLocked(oLocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iVld = 4'b1111; iClr = '0; iLock = '0; iDat = '0;
        #1;
        chk_cnt++; if (oRdy !== 4'b0000) $display("FAIL rst_rdy_comb: got %b expected %b", oRdy, 4'b0000); else pass_cnt++;
        step();
        chk_cnt++; if (oRdy !== 4'b0000) $display("FAIL rst_rdy: got %b expected %b", oRdy, 4'b0000); else pass_cnt++;
        chk_cnt++; if (oDat !== 32'h1) $display("FAIL rst_dat: got %h expected %h", oDat, 32'h1); else pass_cnt++;
        chk_cnt++; if (oGntVld !== 1'b0) $display("FAIL rst_gntvld: got %b expected %b", oGntVld, 1'b0); else pass_cnt++;
        chk_cnt++; if (oLocked !== 1'b0) $display("FAIL rst_locked: got %b expected %b", oLocked, 1'b0); else pass_cnt++;
        chk_cnt++; if (oGntId !== 2'd0) $display("FAIL rst_gntid: got %0d expected %0d", oGntId, 0); else pass_cnt++;
        step();
        rst = 1'b0;
        #1;
        chk_cnt++; if (oRdy !== 4'b0001) $display("FAIL rst_first_grant: got %b expected %b", oRdy, 4'b0001); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        logic [NUM_REQ-1:0] exp_rdy;
        logic [WIDTH-1:0]   exp_dat;
        iVld = 4'b1111; iClr = '0; iLock = '0;
        for (int k = 0; k < NUM_REQ; k++) iDat[k*WIDTH +: WIDTH] = 32'hA0 + k;
        for (int c = 0; c < 5; c++) begin
            exp_rdy = 4'b0001 << exp_id[c];
            exp_dat = 32'hA0 + exp_id[c];
            #1;
            chk_cnt++; if (oRdy !== exp_rdy) $display("FAIL rr_rdy[%0d]: got %b expected %b", c, oRdy, exp_rdy); else pass_cnt++;
            step();
            chk_cnt++; if (oDat !== exp_dat) $display("FAIL rr_dat[%0d]: got %h expected %h", c, oDat, exp_dat); else pass_cnt++;
            chk_cnt++; if (oGntId !== 2'(exp_id[c])) $display("FAIL rr_gntid[%0d]: got %0d expected %0d", c, oGntId, exp_id[c]); else pass_cnt++;
            chk_cnt++; if (oGntVld !== 1'b1) $display("FAIL rr_gntvld[%0d]: got %b expected %b", c, oGntVld, 1'b1); else pass_cnt++;
        end
        iVld = '0;
    endtask

    task automatic test_clear();
        // ptr is 1 here; only req0 is valid so it still wins after wrap-around.
        iVld = 4'b0001; iDat[0 +: WIDTH] = 32'h55;
        step();
        chk_cnt++; if (oDat !== 32'h55) $display("FAIL clr_setup_dat: got %h expected %h", oDat, 32'h55); else pass_cnt++;
        iVld = 4'b0100; iClr = 4'b0100; iDat[2*WIDTH +: WIDTH] = 32'hDEAD;
        #1;
        chk_cnt++; if (oRdy !== 4'b0100) $display("FAIL clr_rdy: got %b expected %b", oRdy, 4'b0100); else pass_cnt++;
        step();
        chk_cnt++; if (oDat !== 32'h1) $display("FAIL clr_dat: got %h expected %h", oDat, 32'h1); else pass_cnt++;
        chk_cnt++; if (oGntId !== 2'd2) $display("FAIL clr_gntid: got %0d expected %0d", oGntId, 2); else pass_cnt++;
        iVld = '0; iClr = '0;
        step();
        chk_cnt++; if (oGntVld !== 1'b0) $display("FAIL clr_idle_gntvld: got %b expected %b", oGntVld, 1'b0); else pass_cnt++;
        chk_cnt++; if (oDat !== 32'h1) $display("FAIL clr_hold_dat: got %h expected %h", oDat, 32'h1); else pass_cnt++;
    endtask

    task automatic test_lock();
        logic [WIDTH-1:0] d;
        iVld = 4'b0010; iLock = 4'b0010; iDat[1*WIDTH +: WIDTH] = 32'h11;
        #1;
        chk_cnt++; if (oRdy !== 4'b0010) $display("FAIL lock_first_rdy: got %b expected %b", oRdy, 4'b0010); else pass_cnt++;
        step();
        chk_cnt++; if (oLocked !== 1'b1) $display("FAIL lock_enter: got %b expected %b", oLocked, 1'b1); else pass_cnt++;
        chk_cnt++; if (oDat !== 32'h11) $display("FAIL lock_first_dat: got %h expected %h", oDat, 32'h11); else pass_cnt++;
        iVld = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            d = 32'h12 + c;
            iDat[1*WIDTH +: WIDTH] = d;
            #1;
            chk_cnt++; if (oRdy !== 4'b0010) $display("FAIL lock_rdy[%0d]: got %b expected %b", c, oRdy, 4'b0010); else pass_cnt++;
            step();
            chk_cnt++; if (oDat !== d) $display("FAIL lock_dat[%0d]: got %h expected %h", c, oDat, d); else pass_cnt++;
            chk_cnt++; if (oLocked !== 1'b1) $display("FAIL lock_hold[%0d]: got %b expected %b", c, oLocked, 1'b1); else pass_cnt++;
        end
        iLock = '0; iDat[1*WIDTH +: WIDTH] = 32'h15;
        #1;
        chk_cnt++; if (oRdy !== 4'b0010) $display("FAIL lock_last_rdy: got %b expected %b", oRdy, 4'b0010); else pass_cnt++;
        step();
        chk_cnt++; if (oLocked !== 1'b0) $display("FAIL lock_release: got %b expected %b", oLocked, 1'b0); else pass_cnt++;
        chk_cnt++; if (oDat !== 32'h15) $display("FAIL lock_last_dat: got %h expected %h", oDat, 32'h15); else pass_cnt++;
        chk_cnt++; if (oRdy !== 4'b0100) $display("FAIL lock_next_rdy: got %b expected %b", oRdy, 4'b0100); else pass_cnt++;
        iVld = '0;
        step();
    endtask

    task automatic test_timeout();
        // ptr is 2 here.
        iVld = 4'b1000; iLock = 4'b1000; iDat[3*WIDTH +: WIDTH] = 32'h33;
        #1;
        chk_cnt++; if (oRdy !== 4'b1000) $display("FAIL to_lock_rdy: got %b expected %b", oRdy, 4'b1000); else pass_cnt++;
        step();
        chk_cnt++; if (oLocked !== 1'b1) $display("FAIL to_lock_enter: got %b expected %b", oLocked, 1'b1); else pass_cnt++;
        iVld = 4'b0001; iLock = '0; iDat[0 +: WIDTH] = 32'h44;
        #1;
        chk_cnt++; if (oRdy !== 4'b0000) $display("FAIL to_blocked_rdy: got %b expected %b", oRdy, 4'b0000); else pass_cnt++;
        for (int c = 0; c < 15; c++) begin
            step();
            chk_cnt++; if (oLocked !== 1'b1) $display("FAIL to_still_locked[%0d]: got %b expected %b", c, oLocked, 1'b1); else pass_cnt++;
        end
        step();
        chk_cnt++; if (oLocked !== 1'b0) $display("FAIL to_release: got %b expected %b", oLocked, 1'b0); else pass_cnt++;
        chk_cnt++; if (oDat !== 32'h33) $display("FAIL to_dat_kept: got %h expected %h", oDat, 32'h33); else pass_cnt++;
        chk_cnt++; if (oGntVld !== 1'b0) $display("FAIL to_gntvld: got %b expected %b", oGntVld, 1'b0); else pass_cnt++;
        chk_cnt++; if (oRdy !== 4'b0001) $display("FAIL to_req0_rdy: got %b expected %b", oRdy, 4'b0001); else pass_cnt++;
        step();
        chk_cnt++; if (oGntId !== 2'd0) $display("FAIL to_req0_gntid: got %0d expected %0d", oGntId, 0); else pass_cnt++;
        chk_cnt++; if (oDat !== 32'h44) $display("FAIL to_req0_dat: got %h expected %h", oDat, 32'h44); else pass_cnt++;
        iVld = '0;
    endtask

    task automatic test_reset_mid_lock();
        // ptr is 1 here.
        iVld = 4'b0010; iLock = 4'b0010; iDat[1*WIDTH +: WIDTH] = 32'h77;
        step();
        chk_cnt++; if (oLocked !== 1'b1) $display("FAIL rml_locked: got %b expected %b", oLocked, 1'b1); else pass_cnt++;
        chk_cnt++; if (oDat !== 32'h77) $display("FAIL rml_dat: got %h expected %h", oDat, 32'h77); else pass_cnt++;
        iDat[1*WIDTH +: WIDTH] = 32'h88;
        rst = 1'b1;
        #1;
        chk_cnt++; if (oRdy !== 4'b0000) $display("FAIL rml_rdy_in_rst: got %b expected %b", oRdy, 4'b0000); else pass_cnt++;
        step();
        rst = 1'b0; iVld = 4'b1111; iLock = '0;
        #1;
        chk_cnt++; if (oLocked !== 1'b0) $display("FAIL rml_unlocked: got %b expected %b", oLocked, 1'b0); else pass_cnt++;
        chk_cnt++; if (oDat !== 32'h1) $display("FAIL rml_dat_ini: got %h expected %h", oDat, 32'h1); else pass_cnt++;
        chk_cnt++; if (oGntVld !== 1'b0) $display("FAIL rml_gntvld: got %b expected %b", oGntVld, 1'b0); else pass_cnt++;
        chk_cnt++; if (oRdy !== 4'b0001) $display("FAIL rml_ptr0_rdy: got %b expected %b", oRdy, 4'b0001); else pass_cnt++;
        iVld = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_clear();
        test_lock();
        test_timeout();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
